pla_sweep_checker: RTL and testbench
====================================

# pla_sweep_checker

Parametrised on-chip exhaustive sweep checker for combinational logic replacements such as the C64 PLA. On `start` it walks every input vector of an `IN_W`-bit space, drives it to the device under test, waits a programmable settle time, and compares the DUT outputs against a reference implementation under a per-bit mask. It counts mismatches, captures the first failing vector, and can halt on first failure. It sits beside the PLA design in `chip_top` as a built-in self-test and replaces simulation-only bench comparison.

## Interface

Parameters:
- `IN_W`, 16, input vector width; sweep covers 0 .. 2^IN_W-1
- `OUT_W`, 8, compared output width
- `SETTLE`, 2, idle cycles between driving a vector and sampling; 0 is legal
- `CNT_W`, 16, width of the saturating mismatch counter

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge
- `rst` input 1: synchronous active-high reset
- `start` input 1: one-cycle start pulse; honoured in IDLE and DONE only
- `stop_on_fail` input 1: sampled with `start`; 1 = halt at first mismatch
- `cmp_mask` input OUT_W: bit 1 = compare that output bit; sampled with `start`
- `in_vec` output IN_W: vector driven to both DUT and reference
- `dut_f` input OUT_W: DUT outputs
- `ref_f` input OUT_W: reference outputs
- `busy` output 1: sweep in progress
- `done` output 1: sweep finished; held until next `start` or `rst`
- `pass` output 1: valid while `done`; 1 = zero mismatches
- `err_count` output CNT_W: mismatching vectors, saturates at 2^CNT_W-1
- `fail_valid` output 1: a first-failure record is captured
- `fail_vec` output IN_W: first failing vector
- `fail_dut` output OUT_W: `dut_f` at first failure
- `fail_ref` output OUT_W: `ref_f` at first failure

## Operation

- States: IDLE, WAIT, CHECK, DONE.
- Reset (any state, including mid-sweep): state IDLE; `in_vec`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `fail_valid`=0, `fail_vec`/`fail_dut`/`fail_ref`=0, settle counter 0.
- IDLE/DONE + `start`: latch `stop_on_fail`, `cmp_mask`; clear `err_count`, `fail_*`, `done`, `pass`; `in_vec`=0; settle counter 0; go WAIT (or CHECK directly if `SETTLE`=0); `busy`=1.
- WAIT: counter increments each cycle; at counter = SETTLE-1 go CHECK.
- CHECK (one cycle): mismatch = |((dut_f ^ ref_f) & latched mask).
  - Mismatch: `err_count`+1 unless saturated; if `fail_valid`=0, capture `fail_vec`=`in_vec`, `fail_dut`, `fail_ref`, set `fail_valid`.
  - Then: if mismatch and latched stop_on_fail -> DONE. Else if `in_vec` = all ones -> DONE. Else `in_vec`+1, counter 0, go WAIT (or stay CHECK if `SETTLE`=0).
- Entering DONE: `busy`=0, `done`=1, `pass` = (err_count after this check == 0).
- `start` during WAIT/CHECK ignored. Mask of all zeros: every vector passes.
- `in_vec` never wraps to 0 within one sweep; the all-ones vector is the final check.

## Timing

- `start` high at edge k: `busy`=1, `in_vec`=0 visible after edge k.
- Each vector held on `in_vec` for exactly SETTLE+1 cycles; compare uses `dut_f`/`ref_f` present during the last of those cycles.
- Full sweep: 2^IN_W × (SETTLE+1) cycles from the edge after `start` to the edge setting `done`; `busy` and `done` never high together.
- Stop on fail at vector v: `done`=1 after edge ending v's CHECK cycle; `in_vec` remains v.
- `err_count`, `fail_*` update on the CHECK edge; stable in DONE.
- `rst` overrides `start` in the same cycle.

## Test plan

- IN_W=4, SETTLE=2, ref = dut = identity function, mask all ones: `start` -> `done` exactly 48 cycles later, `pass`=1, `err_count`=0, `fail_valid`=0.
- Same, DUT bit 0 inverted only for vector 0x9: `err_count`=1, `fail_vec`=0x9, `fail_dut`^`fail_ref`=0x01, `pass`=0, full 48 cycles.
- Same fault, mask = 0xFE: `pass`=1, `err_count`=0.
- DUT wrong for vectors 0x3 and 0xA, `stop_on_fail`=1: `done` after 12 cycles, `fail_vec`=0x3, `err_count`=1, `in_vec`=0x3.
- CNT_W=2, DUT always wrong, SETTLE=0: `err_count` saturates at 3, `done` after 16 cycles, `fail_vec`=0x0.
- Assert `rst` at vector 0x7 mid-sweep: next cycle all outputs at reset values; new `start` restarts from 0; `start` pulsed mid-sweep has no effect.

Source files
------------

// File: rtl/pla_sweep_checker.sv
// Exhaustive input-space sweep checker: walks every IN_W-bit vector, waits SETTLE
// cycles, compares DUT against reference under a mask and records the first failure.
module pla_sweep_checker #(
  parameter int IN_W   = 16,
  parameter int OUT_W  = 8,
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop_on_fail,
  input  logic [OUT_W-1:0] cmp_mask,
  output logic [IN_W-1:0]  in_vec,
  input  logic [OUT_W-1:0] dut_f,
  input  logic [OUT_W-1:0] ref_f,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [IN_W-1:0]  fail_vec,
  output logic [OUT_W-1:0] fail_dut,
  output logic [OUT_W-1:0] fail_ref,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // With SETTLE=0 the wait state is skipped entirely and each vector gets one CHECK cycle.
  localparam int              SC_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [1:0]      S_FIRST = (SETTLE == 0) ? S_CHECK : S_WAIT;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IN_W-1:0]  VEC_LAST = '1;

  logic [1:0]       r_state;
  logic [SC_W-1:0]  r_settle;
  logic [IN_W-1:0]  r_vec;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [CNT_W-1:0] r_err;
  logic             r_fv;
  logic [IN_W-1:0]  r_fvec;
  logic [OUT_W-1:0] r_fdut;
  logic [OUT_W-1:0] r_fref;
  logic             r_stop;
  logic [OUT_W-1:0] r_mask;

  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_next;
  logic             w_finish;

  assign w_mismatch = |((dut_f ^ ref_f) & r_mask);
  assign w_err_next = (w_mismatch && (r_err != CNT_MAX)) ? r_err + 1'b1 : r_err;
  // The all-ones vector is the last one checked; in_vec never wraps inside a sweep.
  assign w_finish   = (w_mismatch && r_stop) || (r_vec == VEC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_settle <= '0;
      r_vec    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pass   <= 1'b0;
      r_err    <= '0;
      r_fv     <= 1'b0;
      r_fvec   <= '0;
      r_fdut   <= '0;
      r_fref   <= '0;
      r_stop   <= 1'b0;
      r_mask   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_stop   <= stop_on_fail;
            r_mask   <= cmp_mask;
            r_err    <= '0;
            r_fv     <= 1'b0;
            r_fvec   <= '0;
            r_fdut   <= '0;
            r_fref   <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_vec    <= '0;
            r_settle <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_FIRST;
          end
        end
        S_WAIT: begin
          if (r_settle == SC_LAST) begin
            r_settle <= '0;
            r_state  <= S_CHECK;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_CHECK: begin
          r_err <= w_err_next;
          if (w_mismatch && !r_fv) begin
            r_fv   <= 1'b1;
            r_fvec <= r_vec;
            r_fdut <= dut_f;
            r_fref <= ref_f;
          end
          if (w_finish) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (w_err_next == '0);
          end else begin
            r_vec    <= r_vec + 1'b1;
            r_settle <= '0;
            r_state  <= S_FIRST;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_vec     = r_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign fail_valid = r_fv;
  assign fail_vec   = r_fvec;
  assign fail_dut   = r_fdut;
  assign fail_ref   = r_fref;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pla_sweep_checker.sv
// Bench for pla_sweep_checker: two instances (SETTLE=2/CNT_W=16 and SETTLE=0/CNT_W=2)
// against a cycle-count model of the sweep, plus hand-computed scenario checks.
module tb_pla_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: IN_W=4, SETTLE=2, CNT_W=16
  logic        start_a, stop_a;
  logic [7:0]  mask_a, fxor_a, dut_f_a, ref_f_a, fdut_a, fref_a;
  logic [15:0] fmap_a;
  logic [3:0]  in_vec_a, fvec_a;
  logic        busy_a, done_a, pass_a, fv_a;
  logic [15:0] err_a;
  logic [1:0]  dbg_a;

  // Instance B: IN_W=4, SETTLE=0, CNT_W=2
  logic        start_b, stop_b;
  logic [7:0]  mask_b, fxor_b, dut_f_b, ref_f_b, fdut_b, fref_b;
  logic [15:0] fmap_b;
  logic [3:0]  in_vec_b, fvec_b;
  logic        busy_b, done_b, pass_b, fv_b;
  logic [1:0]  err_b;
  logic [1:0]  dbg_b;

  assign ref_f_a = {4'b0, in_vec_a};
  assign dut_f_a = ref_f_a ^ (fmap_a[in_vec_a] ? fxor_a : 8'h00);
  assign ref_f_b = {4'b0, in_vec_b};
  assign dut_f_b = ref_f_b ^ (fmap_b[in_vec_b] ? fxor_b : 8'h00);

  pla_sweep_checker #(.IN_W(4), .OUT_W(8), .SETTLE(2), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .stop_on_fail(stop_a), .cmp_mask(mask_a),
    .in_vec(in_vec_a), .dut_f(dut_f_a), .ref_f(ref_f_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .fail_valid(fv_a), .fail_vec(fvec_a),
    .fail_dut(fdut_a), .fail_ref(fref_a), .dbg_state(dbg_a)
  );

  pla_sweep_checker #(.IN_W(4), .OUT_W(8), .SETTLE(0), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .stop_on_fail(stop_b), .cmp_mask(mask_b),
    .in_vec(in_vec_b), .dut_f(dut_f_b), .ref_f(ref_f_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .fail_valid(fv_b), .fail_vec(fvec_b),
    .fail_dut(fdut_b), .fail_ref(fref_b), .dbg_state(dbg_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // Tracks edges since the start edge; vector v is judged on edge (v+1)*(SETTLE+1).
  int         s_of[2]   = '{2, 0};
  int         cmax_of[2] = '{65535, 3};
  int         m_cyc[2], m_err[2], m_vec[2], m_fvec[2];
  bit         m_busy[2], m_done[2], m_pass[2], m_fv[2], m_stop[2];
  logic [7:0] m_fdut[2], m_fref[2], m_mask[2];

  function automatic logic [7:0] model_ref(input int v);
    return 8'(v);
  endfunction

  function automatic logic [7:0] model_dut(input int i, input int v);
    logic [15:0] fm;
    logic [7:0]  fx;
    fm = (i == 0) ? fmap_a : fmap_b;
    fx = (i == 0) ? fxor_a : fxor_b;
    return model_ref(v) ^ (fm[v] ? fx : 8'h00);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      bit st;
      st = (i == 0) ? start_a : start_b;
      if (rst) begin
        m_cyc[i] = 0; m_err[i] = 0; m_vec[i] = 0; m_fvec[i] = 0;
        m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_fv[i] = 0;
        m_fdut[i] = 0; m_fref[i] = 0;
      end else if (st && !m_busy[i]) begin
        m_busy[i] = 1; m_done[i] = 0; m_pass[i] = 0; m_err[i] = 0; m_fv[i] = 0;
        m_fvec[i] = 0; m_fdut[i] = 0; m_fref[i] = 0; m_vec[i] = 0; m_cyc[i] = 0;
        m_stop[i] = (i == 0) ? stop_a : stop_b;
        m_mask[i] = (i == 0) ? mask_a : mask_b;
      end else if (m_busy[i]) begin
        m_cyc[i]++;
        if (m_cyc[i] % (s_of[i] + 1) == 0) begin
          int v;
          bit mis;
          logic [7:0] d, r;
          v   = m_cyc[i] / (s_of[i] + 1) - 1;
          d   = model_dut(i, v);
          r   = model_ref(v);
          mis = ((d ^ r) & m_mask[i]) != 0;
          if (mis) begin
            if (m_err[i] < cmax_of[i]) m_err[i]++;
            if (!m_fv[i]) begin
              m_fv[i] = 1; m_fvec[i] = v; m_fdut[i] = d; m_fref[i] = r;
            end
          end
          if ((mis && m_stop[i]) || v == 15) begin
            m_busy[i] = 0; m_done[i] = 1; m_pass[i] = (m_err[i] == 0);
          end else begin
            m_vec[i] = v + 1;
          end
        end
      end
    end
  end

  task automatic cmp_inst(input int i, input string p, input logic bsy, input logic dn,
                          input logic ps, input int er, input logic fv, input int fvec,
                          input logic [7:0] fd, input logic [7:0] fr, input int vec);
    check({p, "_busy"}, bsy, m_busy[i]);
    check({p, "_done"}, dn, m_done[i]);
    check({p, "_pass"}, ps, m_pass[i]);
    check({p, "_err_count"}, er, m_err[i]);
    check({p, "_fail_valid"}, fv, m_fv[i]);
    check({p, "_fail_vec"}, fvec, m_fvec[i]);
    check({p, "_fail_dut"}, fd, m_fdut[i]);
    check({p, "_fail_ref"}, fr, m_fref[i]);
    check({p, "_in_vec"}, vec, m_vec[i]);
    check({p, "_busy_and_done"}, bsy & dn, 0);
  endtask

  always @(posedge clk) begin
    #1;
    cmp_inst(0, "a", busy_a, done_a, pass_a, int'(err_a), fv_a, int'(fvec_a),
             fdut_a, fref_a, int'(in_vec_a));
    cmp_inst(1, "b", busy_b, done_b, pass_b, int'(err_b), fv_b, int'(fvec_b),
             fdut_b, fref_b, int'(in_vec_b));
  end

  // ---------------- driver ----------------
  function automatic logic done_of(input int inst);
    return (inst == 0) ? done_a : done_b;
  endfunction

  function automatic int vec_of(input int inst);
    return (inst == 0) ? int'(in_vec_a) : int'(in_vec_b);
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start_a = v;
    else start_b = v;
  endtask

  // Pulses start, then counts edges until done; optionally pulses start again mid-sweep.
  task automatic run_sweep(input int inst, input int pulse_at, output int cycles);
    bit pulsed;
    pulsed = 0;
    @(negedge clk); set_start(inst, 1'b1);
    @(negedge clk); set_start(inst, 1'b0);
    cycles = 0;
    while (!done_of(inst) && cycles < 400) begin
      @(negedge clk);
      set_start(inst, 1'b0);
      cycles++;
      if (pulse_at >= 0 && !pulsed && vec_of(inst) == pulse_at && !done_of(inst)) begin
        set_start(inst, 1'b1);
        pulsed = 1;
      end
    end
    set_start(inst, 1'b0);
    check("sweep_reached_done", done_of(inst), 1);
  endtask

  initial begin
    int cyc, n;
    rst = 1'b1;
    start_a = 0; stop_a = 0; mask_a = 8'hFF; fmap_a = 16'h0000; fxor_a = 8'h01;
    start_b = 0; stop_b = 0; mask_b = 8'hFF; fmap_b = 16'h0000; fxor_b = 8'h01;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_in_vec", in_vec_a, 0);
    check("rst_err", err_a, 0);
    check("rst_fail_valid", fv_a, 0);
    rst = 1'b0;

    // Clean sweep, identity DUT
    run_sweep(0, -1, cyc);
    check("t1_cycles", cyc, 48);
    check("t1_pass", pass_a, 1);
    check("t1_err", err_a, 0);
    check("t1_fail_valid", fv_a, 0);
    check("t1_busy", busy_a, 0);

    // Bit 0 wrong for vector 0x9
    fmap_a = 16'h0200;
    run_sweep(0, -1, cyc);
    check("t2_cycles", cyc, 48);
    check("t2_err", err_a, 1);
    check("t2_fail_vec", fvec_a, 4'h9);
    check("t2_fail_xor", fdut_a ^ fref_a, 8'h01);
    check("t2_pass", pass_a, 0);
    check("t2_in_vec_last", in_vec_a, 4'hF);

    // Same fault masked off
    mask_a = 8'hFE;
    run_sweep(0, -1, cyc);
    check("t3_pass", pass_a, 1);
    check("t3_err", err_a, 0);
    check("t3_fail_valid", fv_a, 0);

    // Stop on first failure at 0x3 (0xA never reached)
    mask_a = 8'hFF; fmap_a = 16'h0408; stop_a = 1;
    run_sweep(0, -1, cyc);
    check("t4_cycles", cyc, 12);
    check("t4_fail_vec", fvec_a, 4'h3);
    check("t4_err", err_a, 1);
    check("t4_in_vec", in_vec_a, 4'h3);
    check("t4_pass", pass_a, 0);
    stop_a = 0;

    // Saturating counter, SETTLE=0
    fmap_b = 16'hFFFF;
    run_sweep(1, -1, cyc);
    check("t5_cycles", cyc, 16);
    check("t5_err_sat", err_b, 3);
    check("t5_fail_vec", fvec_b, 4'h0);
    check("t5_pass", pass_b, 0);

    // Reset mid-sweep at vector 0x7 (fault at 0x2 so failure state is populated)
    fmap_a = 16'h0004;
    @(negedge clk); start_a = 1;
    @(negedge clk); start_a = 0;
    n = 0;
    while (in_vec_a != 4'h7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_reach_7", in_vec_a, 4'h7);
    check("t6_pre_fail_valid", fv_a, 1);
    rst = 1'b1; start_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; start_a = 1'b0;
    check("t6_busy", busy_a, 0);
    check("t6_done", done_a, 0);
    check("t6_pass", pass_a, 0);
    check("t6_in_vec", in_vec_a, 0);
    check("t6_err", err_a, 0);
    check("t6_fail_valid", fv_a, 0);
    check("t6_fail_vec", fvec_a, 0);
    check("t6_fail_dut", fdut_a, 0);
    check("t6_fail_ref", fref_a, 0);

    // Restart from 0 with a start pulse mid-sweep that must be ignored
    fmap_a = 16'h0000;
    run_sweep(0, 5, cyc);
    check("t6_restart_cycles", cyc, 48);
    check("t6_restart_pass", pass_a, 1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
